multi_btn_countdown: RTL and testbench

- Parametrised successor to the two-button LED down-counter subsystem.
- Three push-buttons, each with its own debounce and one-pulse stage, drive a start/pause/done state machine.
- A prescaled countdown of width LED_W is shown on a thermometer-coded LED bar.
- Adds pause/resume, a selectable one-shot or auto-reload mode, and status outputs.
- Sits at board top level between the raw buttons and the LED bank.

---
 rtl/multi_btn_countdown.sv | 159 +++++++++++++++
 tb/tb_multi_btn_countdown.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_btn_countdown.sv
// Three-button countdown: debounced start/pause, restart and mode keys drive a thermometer LED bar.
// Optional DONE-state blinking is enabled by defining MULTI_BTN_COUNTDOWN_BLINK_EN.
module multi_btn_countdown #(
    parameter int unsigned LED_W    = 16,
    parameter int unsigned DEB_LEN  = 4,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       btn,
    output logic [LED_W-1:0] led,
    output logic             running,
    output logic             done,
    output logic             mode
);

    localparam int unsigned NBTN  = 3;
    localparam int unsigned CNT_W = $clog2(LED_W + 1);
    localparam int unsigned PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    logic [DEB_LEN-1:0] r_sr [NBTN];
    logic [NBTN-1:0]    r_hist;
    logic [NBTN-1:0]    r_pulse;
    logic [NBTN-1:0]    w_lvl;

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [PSC_W-1:0]   r_psc, w_psc_nx, w_psc_inc;
    logic               r_mode, w_mode_nx;
    logic               r_blink, w_blink_nx;
    logic [LED_W-1:0]   r_led, w_led_nx;
    logic               r_running, r_done;
    logic               w_wrap, w_start, w_restart, w_toggle;

    // Debounce level holds between all-ones and all-zeros windows; r_hist is that held level.
    always_comb begin
        w_lvl = '0;
        for (int b = 0; b < NBTN; b++) begin
            w_lvl[b] = (&r_sr[b]) | (~(~|r_sr[b]) & r_hist[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBTN; b++) r_sr[b] <= '0;
            r_hist  <= '0;
            r_pulse <= '0;
        end else begin
            for (int b = 0; b < NBTN; b++) r_sr[b] <= {r_sr[b][DEB_LEN-2:0], btn[b]};
            r_hist  <= w_lvl;
            r_pulse <= w_lvl & ~r_hist;
        end
    end

    assign w_start   = r_pulse[0];
    assign w_restart = r_pulse[1];
    assign w_toggle  = r_pulse[2];
    assign w_wrap    = (r_psc == PSC_W'(TICK_DIV - 1));
    assign w_psc_inc = w_wrap ? '0 : r_psc + PSC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_W'(LED_W);
            r_psc     <= '0;
            r_mode    <= 1'b0;
            r_blink   <= 1'b0;
            r_led     <= '1;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_psc     <= w_psc_nx;
            r_mode    <= w_mode_nx;
            r_blink   <= w_blink_nx;
            r_led     <= w_led_nx;
            r_running <= (w_state_nx == S_RUN);
            r_done    <= (w_state_nx == S_DONE);
        end
    end

    // Next state; the prescaler still advances in the RUN cycle a pause pulse arrives, so that tick is lost.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_psc_nx   = r_psc;
        w_mode_nx  = r_mode ^ w_toggle;
        w_blink_nx = r_blink;
        if (w_restart) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = CNT_W'(LED_W);
            w_psc_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_state_nx = S_RUN;
                        w_psc_nx   = '0;
                    end
                end
                S_RUN: begin
                    w_psc_nx = w_psc_inc;
                    if (w_start) begin
                        w_state_nx = S_PAUSE;
                    end else if (w_wrap) begin
                        if (r_cnt != CNT_W'(1)) begin
                            w_cnt_nx = r_cnt - CNT_W'(1);
                        end else if (r_mode) begin
                            w_cnt_nx = CNT_W'(LED_W);
                        end else begin
                            w_cnt_nx   = '0;
                            w_state_nx = S_DONE;
                            w_blink_nx = 1'b0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_start) w_state_nx = S_RUN;
                end
                S_DONE: begin
                    if (w_start) begin
                        w_state_nx = S_RUN;
                        w_cnt_nx   = CNT_W'(LED_W);
                        w_psc_nx   = '0;
                    end else begin
`ifdef MULTI_BTN_COUNTDOWN_BLINK_EN
                        w_psc_nx = w_psc_inc;
                        if (w_wrap) w_blink_nx = ~r_blink;
`else
                        w_psc_nx = '0;
`endif
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Thermometer encode the next count; DONE shows the blink phase (always zero without blinking).
    always_comb begin
        w_led_nx = '0;
        if (w_state_nx == S_DONE) begin
            w_led_nx = w_blink_nx ? '1 : '0;
        end else begin
            for (int i = 0; i < LED_W; i++) begin
                w_led_nx[i] = (CNT_W'(i) < w_cnt_nx);
            end
        end
    end

    assign led     = r_led;
    assign running = r_running;
    assign done    = r_done;
    assign mode    = r_mode;

endmodule

// File: tb/tb_multi_btn_countdown.sv
// Directed bench for multi_btn_countdown with default parameters (16 LEDs, 4-sample debounce, /4 tick).
module tb_multi_btn_countdown;

    logic        clk;
    logic        rst_n;
    logic [2:0]  btn;
    logic [15:0] led;
    logic        running;
    logic        done;
    logic        mode;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]  btn;
        int          cyc;
        logic [15:0] led;
        logic        run;
        logic        dn;
        logic        md;
    } vec_t;

    vec_t tbl[$];

    multi_btn_countdown #(.LED_W(16), .DEB_LEN(4), .TICK_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .led     (led),
        .running (running),
        .done    (done),
        .mode    (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] therm(input int n);
        logic [31:0] t;
        t = (32'd1 << n) - 32'd1;
        return (n >= 16) ? 16'hFFFF : t[15:0];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [15:0] l, input logic r,
                           input logic d, input logic m);
        chk({nm, ".led"}, 32'(led), 32'(l));
        chk({nm, ".running"}, 32'(running), 32'(r));
        chk({nm, ".done"}, 32'(done), 32'(d));
        chk({nm, ".mode"}, 32'(mode), 32'(m));
    endtask

    // Button press: state effect lands on the 6th edge after btn rises (debounce 4 + pulse 1 + update 1).
    task automatic press(input logic [2:0] b);
        btn = b;
        step(6);
        btn = 3'b000;
    endtask

    initial begin
        bit done_seen;
        n_checks  = 0;
        n_fail    = 0;
        btn       = 3'b000;
        rst_n     = 1'b0;
        done_seen = 1'b0;

        // Main one-shot scenario as {btn, cycles, expected outputs} vectors.
        tbl.push_back('{3'b001, 6, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        for (int j = 1; j <= 15; j++) tbl.push_back('{3'b000, 4, therm(16 - j), 1'b1, 1'b0, 1'b0});
        tbl.push_back('{3'b000, 4, 16'h0000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{3'b000, 8, 16'h0000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{3'b001, 6, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{3'b000, 4, 16'h7FFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{3'b010, 6, 16'hFFFF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3'b100, 6, 16'hFFFF, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{3'b000, 6, 16'hFFFF, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{3'b100, 6, 16'hFFFF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3'b000, 5, 16'hFFFF, 1'b0, 1'b0, 1'b0});

        step(2);
        chk_out("reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(2);
        chk_out("post_reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Glitch shorter than the debounce window.
        btn = 3'b001;
        step(3);
        btn = 3'b000;
        step(10);
        chk_out("glitch", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Long hold: exactly one start pulse, RUN on the 6th edge.
        btn = 3'b001;
        step(5);
        chk("hold_k4.running", 32'(running), 32'd0);
        step(1);
        chk("hold_k5.running", 32'(running), 32'd1);
        step(14);
        chk_out("hold_20", 16'h1FFF, 1'b1, 1'b0, 1'b0);
        btn = 3'b000;
        press(3'b010);
        chk_out("restart_idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            btn = tbl[i].btn;
            step(tbl[i].cyc);
            chk_out($sformatf("vec%0d", i), tbl[i].led, tbl[i].run, tbl[i].dn, tbl[i].md);
        end
        btn = 3'b000;

        // Pause at count 10 with prescaler phase 2, resume two cycles before the next step.
        press(3'b001);
        step(20);
        chk("pause_pre.led", 32'(led), 32'(therm(11)));
        press(3'b001);
        chk_out("paused", 16'h03FF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(10);
            chk($sformatf("pause_hold%0d.led", i), 32'(led), 32'h03FF);
        end
        press(3'b001);
        chk_out("resumed", 16'h03FF, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("resume_r1.led", 32'(led), 32'h03FF);
        step(1);
        chk("resume_r2.led", 32'(led), 32'h01FF);

        // Auto-reload: count 1 reloads to full, DONE never seen.
        press(3'b010);
        press(3'b100);
        chk_out("mode_on", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        press(3'b001);
        for (int i = 0; i < 60; i++) begin
            step(1);
            done_seen |= done;
        end
        chk("reload_c1.led", 32'(led), 32'h0001);
        for (int i = 0; i < 8; i++) begin
            step(1);
            done_seen |= done;
            if (i == 3) chk_out("reload_full", 16'hFFFF, 1'b1, 1'b0, 1'b1);
        end
        chk("reload_next.led", 32'(led), 32'h7FFF);
        chk("reload_done_seen", 32'(done_seen), 32'd0);

        // Start and restart together: restart wins.
        press(3'b011);
        chk_out("start_restart", 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Mode toggle in the same cycle as the final one-shot tick.
        press(3'b100);
        chk("mode_off", 32'(mode), 32'd0);
        press(3'b001);
        step(58);
        btn = 3'b100;
        step(5);
        chk_out("tick_pre", 16'h0001, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("tick_toggle", 16'h0000, 1'b0, 1'b1, 1'b1);
        btn = 3'b000;

        // Asynchronous reset mid-RUN at count 7.
        press(3'b001);
        step(36);
        chk_out("pre_reset", 16'h007F, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_out("async_reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk_out("after_reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
